// File: rtl/capiano_pkg.sv
// rtl/capiano_pkg.sv - frame geometry, key count and capture state encoding shared by the key scanner
package capiano_pkg;
    localparam int FRAME_W = 320;
    localparam int FRAME_H = 240;
    localparam int KEYS    = 40;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [3:0] {
        WAIT_FS = 4'd0,
        ACCUM   = 4'd1,
        EVAL    = 4'd2
    } cap_state_e;
endpackage

// File: rtl/pix_pos_ctr.sv
// rtl/pix_pos_ctr.sv - raster x/y position of the incoming pixel with clear, advance and end-of-frame
module pix_pos_ctr
    import capiano_pkg::*;
#(
    parameter int FRAME_W_P = FRAME_W,
    parameter int FRAME_H_P = FRAME_H
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           adv,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           eof
);
    localparam logic [X_W-1:0] X_LAST = X_W'(FRAME_W_P - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_H_P - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    // clr re-bases the current pixel to (0,0) so a pixel arriving with frame_start opens the new frame
    always_comb begin
        pos_x = clr ? '0 : x_q;
        pos_y = clr ? '0 : y_q;
        eof   = adv && (pos_x == X_LAST) && (pos_y == Y_LAST);
        x_d   = pos_x;
        y_d   = pos_y;
        if (adv) begin
            if (pos_x == X_LAST) begin
                x_d = '0;
                y_d = pos_y + 1'b1;
            end else begin
                x_d = pos_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/key_scanner.sv
// rtl/key_scanner.sv - counts dark pixels per piano key column and hands changed key bitmaps to the UART
module key_scanner #(
    parameter int KEYS     = capiano_pkg::KEYS,
    parameter int KEY_W    = 8,
    parameter int ROW_TOP  = 200,
    parameter int ROW_BOT  = 231,
    parameter int DARK_LVL = 9,
    parameter int THRESH   = 64,
    parameter int FRAME_W  = capiano_pkg::FRAME_W,
    parameter int FRAME_H  = capiano_pkg::FRAME_H
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            pix_valid,
    input  logic [8:0]      pix_data,
    output logic [KEYS-1:0] keys,
    output logic            send,
    input  logic            send_done,
    output logic [3:0]      sta,
    output logic [3:0]      frame_cnt
);
    import capiano_pkg::*;

    localparam logic [Y_W-1:0]   ROW_TOP_L = Y_W'(ROW_TOP);
    localparam logic [Y_W-1:0]   ROW_BOT_L = Y_W'(ROW_BOT);
    localparam logic [4:0]       DARK_L    = 5'(DARK_LVL);
    localparam logic [CNT_W-1:0] THRESH_L  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    cap_state_e       state_q, state_d;
    logic [X_W-1:0]   pos_x, key_idx;
    logic [Y_W-1:0]   pos_y;
    logic             eof, pos_clr, pos_adv, dark_hit, evaluating;
    logic [4:0]       lum;
    logic [CNT_W-1:0] cnt_q [KEYS];
    logic [CNT_W-1:0] cnt_d [KEYS];
    logic [KEYS-1:0]  result, cand;
    logic [KEYS-1:0]  keys_q, keys_d, last_q, last_d, pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d, send_q, send_d;
    logic [3:0]       frame_cnt_q, frame_cnt_d;

    pix_pos_ctr #(
        .FRAME_W_P (FRAME_W),
        .FRAME_H_P (FRAME_H)
    ) u_pos (
        .clk   (clk),
        .rst   (rst),
        .clr   (pos_clr),
        .adv   (pos_adv),
        .pos_x (pos_x),
        .pos_y (pos_y),
        .eof   (eof)
    );

    always_comb begin
        state_d     = state_q;
        pos_clr     = 1'b0;
        pos_adv     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            WAIT_FS: begin
                if (frame_start) begin
                    state_d = ACCUM;
                    pos_clr = 1'b1;
                    pos_adv = pix_valid;
                end
            end
            ACCUM: begin
                pos_clr = frame_start;
                pos_adv = pix_valid;
                if (eof) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                state_d     = WAIT_FS;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            default: state_d = WAIT_FS;
        endcase
    end

    assign lum      = {2'b00, pix_data[8:6]} + {2'b00, pix_data[5:3]} + {2'b00, pix_data[2:0]};
    assign dark_hit = pos_adv && (lum < DARK_L) && (pos_y >= ROW_TOP_L) && (pos_y <= ROW_BOT_L);
    assign key_idx  = pos_x / X_W'(KEY_W);

    always_comb begin
        for (int k = 0; k < KEYS; k++) begin
            cnt_d[k] = pos_clr ? '0 : cnt_q[k];
            if (dark_hit && (key_idx == X_W'(k)) && (cnt_d[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_d[k] + 1'b1;
            end
            result[k] = cnt_q[k] >= THRESH_L;
        end
    end

    // A fresh evaluation supersedes whatever is pending when both compete for the idle send slot
    always_comb begin
        evaluating = (state_q == EVAL);
        cand       = evaluating ? result : pend_q;
        keys_d     = keys_q;
        last_d     = last_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        send_d     = send_q;
        if (send_q) begin
            if (evaluating) begin
                pend_d     = result;
                pend_vld_d = 1'b1;
            end
            if (send_done) begin
                send_d = 1'b0;
                last_d = keys_q;
            end
        end else if (evaluating || pend_vld_q) begin
            pend_vld_d = 1'b0;
            if (cand != last_q) begin
                keys_d = cand;
                send_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= WAIT_FS;
            keys_q      <= '0;
            last_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            send_q      <= 1'b0;
            frame_cnt_q <= '0;
            for (int k = 0; k < KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            keys_q      <= keys_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            send_q      <= send_d;
            frame_cnt_q <= frame_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign keys      = keys_q;
    assign send      = send_q;
    assign sta       = state_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_key_scanner.sv
// tb/tb_key_scanner.sv - scoreboard bench for key_scanner on a reduced 4-key, 32x36 frame
module tb_key_scanner;
    localparam int KEYS = 4, KEY_W = 8, ROW_TOP = 2, ROW_BOT = 33;
    localparam int DARK_LVL = 9, THRESH = 64, FRAME_W = 32, FRAME_H = 36;

    logic clk = 1'b0, rst = 1'b0, frame_start = 1'b0, pix_valid = 1'b0, send_done = 1'b0;
    logic [8:0] pix_data = '0;
    logic [KEYS-1:0] keys;
    logic send;
    logic [3:0] sta, frame_cnt;

    int n_checks = 0, n_fail = 0;
    logic [KEYS-1:0] exp_q[$];

    int dark_n[KEYS];
    logic [8:0] dk_pix, nd_pix;
    bit oob_dark;
    logic [KEYS-1:0] last_m, keys_m, pend_m;
    bit send_m, pend_vld_m;
    logic [3:0] fc_m;

    key_scanner #(
        .KEYS(KEYS), .KEY_W(KEY_W), .ROW_TOP(ROW_TOP), .ROW_BOT(ROW_BOT),
        .DARK_LVL(DARK_LVL), .THRESH(THRESH), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .keys(keys), .send(send), .send_done(send_done),
        .sta(sta), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    function automatic logic [8:0] pix_at(int x, int y);
        int idx;
        if (y >= ROW_TOP && y <= ROW_BOT) begin
            idx = (y - ROW_TOP) * KEY_W + (x % KEY_W);
            return (idx < dark_n[x / KEY_W]) ? dk_pix : nd_pix;
        end
        return oob_dark ? dk_pix : nd_pix;
    endfunction

    function automatic logic [KEYS-1:0] exp_result();
        logic [KEYS-1:0] r;
        for (int k = 0; k < KEYS; k++) r[k] = (((dark_n[k] > 255) ? 255 : dark_n[k]) >= THRESH);
        return r;
    endfunction

    task automatic set_frame(input int d0, d1, d2, d3, input logic [8:0] dk, nd, input bit oob);
        dark_n[0] = d0; dark_n[1] = d1; dark_n[2] = d2; dark_n[3] = d3;
        dk_pix = dk; nd_pix = nd; oob_dark = oob;
    endtask

    task automatic drive_frame(input int stop_y, input bit fs_with_pix);
        frame_start = 1'b1;
        if (!fs_with_pix) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
        for (int y = 0; y < FRAME_H; y++) begin
            for (int x = 0; x < FRAME_W; x++) begin
                if (y == stop_y) begin
                    pix_valid = 1'b0;
                    return;
                end
                pix_valid = 1'b1;
                pix_data  = pix_at(x, y);
                @(posedge clk); #1;
                frame_start = 1'b0;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        logic [KEYS-1:0] res, exp_k;
        bit new_send;
        n_checks++;
        if (sta !== 4'd2) begin n_fail++; $display("FAIL %s_eval_sta: got %0d want 2", tag, sta); end
        res = exp_result();
        fc_m = fc_m + 4'd1;
        new_send = 1'b0;
        if (send_m) begin
            pend_m = res; pend_vld_m = 1'b1;
        end else if (res != last_m) begin
            keys_m = res; send_m = 1'b1; new_send = 1'b1; exp_q.push_back(res);
        end
        @(posedge clk); #1;
        n_checks++;
        if (frame_cnt !== fc_m) begin n_fail++; $display("FAIL %s_frame_cnt: got %0d want %0d", tag, frame_cnt, fc_m); end
        n_checks++;
        if (sta !== 4'd0) begin n_fail++; $display("FAIL %s_idle_sta: got %0d want 0", tag, sta); end
        n_checks++;
        if (send !== send_m) begin n_fail++; $display("FAIL %s_send: got %b want %b", tag, send, send_m); end
        exp_k = new_send ? exp_q.pop_front() : keys_m;
        n_checks++;
        if (keys !== exp_k) begin n_fail++; $display("FAIL %s_keys: got %h want %h", tag, keys, exp_k); end
    endtask

    task automatic handshake(input string tag);
        bit resend;
        logic [KEYS-1:0] exp_k;
        resend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({send, keys} !== {1'b1, keys_m}) begin
            n_fail++; $display("FAIL %s_hold: send=%b keys=%h want send=1 keys=%h", tag, send, keys, keys_m);
        end
        send_done = 1'b1;
        @(posedge clk); #1;
        send_done = 1'b0;
        send_m = 1'b0; last_m = keys_m;
        if (pend_vld_m) begin
            pend_vld_m = 1'b0;
            if (pend_m != last_m) begin
                keys_m = pend_m; send_m = 1'b1; resend = 1'b1; exp_q.push_back(pend_m);
            end
        end
        n_checks++;
        if (send !== 1'b0) begin n_fail++; $display("FAIL %s_drop: send=%b want 0", tag, send); end
        @(posedge clk); #1;
        n_checks++;
        if (send !== send_m) begin n_fail++; $display("FAIL %s_resend: send=%b want %b", tag, send, send_m); end
        if (resend) begin
            exp_k = exp_q.pop_front();
            n_checks++;
            if (keys !== exp_k) begin n_fail++; $display("FAIL %s_resend_keys: got %h want %h", tag, keys, exp_k); end
        end
    endtask

    task automatic model_reset();
        last_m = '0; keys_m = '0; pend_m = '0; send_m = 1'b0; pend_vld_m = 1'b0; fc_m = '0;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        n_checks++;
        if ({send, keys, sta, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL %s: send=%b keys=%h sta=%0d frame_cnt=%0d want all 0", tag, send, keys, sta, frame_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_all_white();
        set_frame(0, 0, 0, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("white");
    endtask

    task automatic test_single_key();
        set_frame(0, 0, 256, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("key2");
        handshake("key2_hs");
    endtask

    task automatic test_threshold();
        set_frame(63, 0, 0, 0, 9'h000, 9'h1D0, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("thr63");
        handshake("thr63_hs");
        set_frame(64, 60, 0, 0, 9'h1C8, 9'h1D0, 1'b1);
        drive_frame(-1, 1'b0);
        finish_frame("thr64");
        handshake("thr64_hs");
        set_frame(64, 256, 0, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("sat");
        handshake("sat_hs");
        drive_frame(-1, 1'b0);
        finish_frame("unchanged");
    endtask

    task automatic test_abort();
        set_frame(256, 0, 0, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(18, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sta, frame_cnt, send} !== {4'd1, fc_m, 1'b0}) begin
            n_fail++; $display("FAIL abort_no_eval: sta=%0d frame_cnt=%0d send=%b", sta, frame_cnt, send);
        end
        set_frame(0, 0, 0, 255, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b1);
        finish_frame("after_abort");
    endtask

    task automatic test_back_to_back();
        set_frame(64, 0, 0, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("b2b_1");
        set_frame(0, 64, 0, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("b2b_2");
        set_frame(0, 0, 64, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("b2b_3");
        handshake("b2b_hs");
        handshake("b2b_final_hs");
    endtask

    task automatic test_stray_done();
        send_done = 1'b1;
        @(posedge clk); #1;
        send_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({send, keys} !== {1'b0, keys_m}) begin
            n_fail++; $display("FAIL stray_done: send=%b keys=%h want 0 %h", send, keys, keys_m);
        end
        drive_frame(-1, 1'b0);
        finish_frame("stray_unchanged");
    endtask

    task automatic test_reset_mid();
        set_frame(0, 64, 64, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("pre_rst");
        set_frame(256, 256, 256, 256, 9'h000, 9'h1FF, 1'b0);
        drive_frame(20, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("mid_reset");
        rst = 1'b1;
        model_reset();
        set_frame(64, 0, 0, 0, 9'h000, 9'h1FF, 1'b0);
        drive_frame(-1, 1'b0);
        finish_frame("post_rst");
        handshake("post_rst_hs");
    endtask

    initial begin
        test_reset();
        test_all_white();
        test_single_key();
        test_threshold();
        test_abort();
        test_back_to_back();
        test_stray_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/key_scanner.md
KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- KEYS, 40, number of piano key columns.
- KEY_W, 8, pixels per key column (KEYS*KEY_W = 320 = frame width).
- ROW_TOP, 200, first frame row of the key band.
- ROW_BOT, 231, last frame row of the key band.
- DARK_LVL, 9, pixel is dark when r+g+b < DARK_LVL.
- THRESH, 64, minimum dark-pixel count for a key to be pressed.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock.
- rst, in, 1, synchronous active-low reset.
- frame_start, in, 1, one-cycle pulse at the start of each camera frame.
- pix_valid, in, 1, pix_data carries one pixel this cycle, raster order, 320x240.
- pix_data, in, 9, RGB 3:3:3 as {r[8:6], g[5:3], b[2:0]}.
- keys, out, 40, pressed-key bitmap; bit k = key column k; drives the UART controller data input.
- send, out, 1, request to transmit keys.
- send_done, in, 1, one-cycle pulse from the UART controller when keys has been sent.
- sta, out, 4, capture state encoding, for debug digit display.
- frame_cnt, out, 4, evaluated-frame counter, wraps 15->0, debug.

Function
REQ-003 Capture FSM states: WAIT_FS=0, ACCUM=1, EVAL=2; sta SHALL equal the current state code.
REQ-004 WAIT_FS->ACCUM on frame_start; x, y and all key counters SHALL clear on that edge.
REQ-005 In ACCUM each pix_valid SHALL advance x 0..319, then wrap to 0 and increment y; at x=319, y=239 the FSM SHALL go to EVAL next cycle.
REQ-006 A pixel SHALL be dark when the 5-bit sum r+g+b < DARK_LVL; a dark pixel with ROW_TOP<=y<=ROW_BOT increments counter[x/KEY_W].
REQ-007 Key counters SHALL be 8 bits wide and saturate at 255.
REQ-008 EVAL SHALL last exactly one cycle: result[k] = (counter[k] >= THRESH); frame_cnt increments; FSM returns to WAIT_FS.
REQ-009 frame_start in ACCUM SHALL abort the partial frame without evaluation, clear counters and x/y, and stay in ACCUM.
REQ-010 frame_start and pix_valid in the same cycle SHALL count that pixel as x=0, y=0 of the new frame.
REQ-011 pix_valid in WAIT_FS or EVAL SHALL be ignored.
REQ-012 Send side: when EVAL produces a result differing from the last transmitted bitmap and send is low, keys SHALL load the result and send SHALL rise the following cycle.
REQ-013 send SHALL stay high and keys stable until send_done; send SHALL drop the cycle after send_done.
REQ-014 A result arriving while send is high SHALL be held in a single pending register, newest overwriting older.
REQ-015 After send drops, if the pending result differs from the bitmap just sent, the block SHALL reload keys and reassert send after exactly one low cycle.
REQ-016 send_done while send is low SHALL be ignored.
REQ-017 An unchanged result SHALL NOT raise send.

Reset
REQ-018 While rst=0 at a clk edge, these SHALL clear to 0: state (WAIT_FS), x, y, counters, keys, last-sent bitmap, pending register and pending flag, send, frame_cnt.
REQ-019 A reset asserted mid-frame or mid-handshake SHALL drop send the cycle after the reset edge and discard all partial results.

Structure
REQ-020 The shared package capiano_pkg SHALL hold the FRAME_W=320, FRAME_H=240 and KEYS constants and the state encodings.
REQ-021 The x/y raster position counter SHALL be one sub-module, pix_pos_ctr, with clear, advance and end-of-frame outputs.

Verification
REQ-022 Frame with all pixels 9'h1FF -> no send; frame_cnt=1 after EVAL.
REQ-023 Frame with columns x=16..23, rows 200..231 at 9'h000, all else white -> keys=40'h0000000004 and send high until a send_done pulse.
REQ-024 Key column 0 has 63 dark band pixels -> bit0=0; with 64 -> bit0=1; 255+ dark pixels -> counter saturates at 255, no wrap.
REQ-025 frame_start injected at y=120 -> no EVAL for the aborted frame; the next full frame evaluates normally.
REQ-026 Three differing results while send is held high -> exactly one resend after send_done, carrying the third result.
REQ-027 rst=0 during send high -> send=0 and keys=0 the cycle after the reset edge; the first post-reset frame evaluates correctly.
